// File: rtl/fir_result_pkg.sv
// Shared constants and the accumulator-to-sample rescaling helper for the FIR
// result buffer.
package fir_result_pkg;

  localparam int ACC_WIDTH         = 19;
  localparam int DEFAULT_SHIFT     = 8;
  localparam int DEFAULT_OUT_WIDTH = 8;
  localparam int DEFAULT_DEPTH     = 4;
  localparam int DROP_MAX          = 255;
  localparam int MAX_OUT_WIDTH     = 16;

  typedef struct packed {
    logic [MAX_OUT_WIDTH-1:0] value;
    logic                     clamped;
  } sat_result_t;

  // Round half up, then clamp to a signed 'width'-bit range.
  function automatic sat_result_t sat_round(input logic signed [ACC_WIDTH:0] x,
                                            input int shift, input int width);
    int          y;
    int          hi;
    int          lo;
    sat_result_t r;
    y = int'(x);
    if (shift > 0) y = (y + (1 << (shift - 1))) >>> shift;
    hi = (1 << (width - 1)) - 1;
    lo = -hi - 1;
    r.clamped = 1'b0;
    if (y > hi) begin
      y         = hi;
      r.clamped = 1'b1;
    end else if (y < lo) begin
      y         = lo;
      r.clamped = 1'b1;
    end
    r.value = MAX_OUT_WIDTH'(y);
    return r;
  endfunction

endpackage

// File: rtl/fir_result_fifo.sv
// Small power-of-two FIFO with an explicit occupancy counter and no
// write-to-read bypass.
module fir_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_level == '0);
  assign full   = (r_level == (PTR_W + 1)'(DEPTH));
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  // NOTE: storage is left unreset; stale entries are never visible because dout is masked while empty.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign dout  = empty ? '0 : r_mem[r_rd_ptr];
  assign level = r_level;

endmodule

// File: rtl/fir_result_buffer.sv
// Rescales FIR accumulator results to OUT_WIDTH samples and queues them on a
// valid/ready interface with sticky saturation and drop-count status.
module fir_result_buffer
  import fir_result_pkg::*;
#(
  parameter int SHIFT     = DEFAULT_SHIFT,
  parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [31:0]            RESULT,
  input  logic                   OUTPUT_DATA_READY,
  output logic [OUT_WIDTH-1:0]   OUT_DATA,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic                   SAT_FLAG,
  output logic [7:0]             DROP_COUNT,
  output logic [$clog2(DEPTH):0] LEVEL
);

  logic signed [ACC_WIDTH:0] w_x;
  sat_result_t               w_sat;
  logic                      w_unused;
  logic                      r_s1_valid;
  logic                      r_s1_clamped;
  logic [OUT_WIDTH-1:0]      r_s1_data;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_drop;

  assign w_x      = {RESULT[ACC_WIDTH-1], RESULT[ACC_WIDTH-1:0]};
  assign w_sat    = sat_round(w_x, SHIFT, OUT_WIDTH);
  assign w_unused = ^{RESULT[31:ACC_WIDTH], w_sat.value};

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_s1_valid   <= 1'b0;
      r_s1_clamped <= 1'b0;
      r_s1_data    <= '0;
    end else begin
      r_s1_valid <= OUTPUT_DATA_READY;
      if (OUTPUT_DATA_READY) begin
        r_s1_data    <= w_sat.value[OUT_WIDTH-1:0];
        r_s1_clamped <= w_sat.clamped;
      end
    end
  end

  // A full FIFO still accepts the sample when the consumer pops in the same cycle.
  assign w_pop  = OUT_READY && !w_empty;
  assign w_push = r_s1_valid && (!w_full || w_pop);
  assign w_drop = r_s1_valid && !w_push;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      SAT_FLAG   <= 1'b0;
      DROP_COUNT <= '0;
    end else begin
      if (r_s1_valid && r_s1_clamped) SAT_FLAG <= 1'b1;
      if (w_drop && (DROP_COUNT != 8'(DROP_MAX))) DROP_COUNT <= DROP_COUNT + 8'd1;
    end
  end

  fir_result_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_s1_data),
    .dout  (OUT_DATA),
    .level (LEVEL),
    .full  (w_full),
    .empty (w_empty)
  );

  assign OUT_VALID = !w_empty;

endmodule

// File: tb/tb_fir_result_buffer.sv
// Scoreboard bench for fir_result_buffer: a queue-based reference model
// predicts contents and status, and a negedge monitor compares every cycle.
module tb_fir_result_buffer;

  localparam int SHIFT     = 8;
  localparam int OUT_WIDTH = 8;
  localparam int DEPTH     = 4;
  localparam int LVL_W     = $clog2(DEPTH) + 1;

  logic                 CLK = 1'b0;
  logic                 RESET = 1'b1;
  logic [31:0]          RESULT = '0;
  logic                 OUTPUT_DATA_READY = 1'b0;
  logic                 OUT_READY = 1'b0;
  logic [OUT_WIDTH-1:0] OUT_DATA;
  logic                 OUT_VALID;
  logic                 SAT_FLAG;
  logic [7:0]           DROP_COUNT;
  logic [LVL_W-1:0]     LEVEL;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [OUT_WIDTH-1:0] exp_q[$];
  bit                   m_s1_v = 0;
  logic [OUT_WIDTH-1:0] m_s1_d = '0;
  bit                   m_s1_c = 0;
  bit                   m_sat = 0;
  int                   m_drop = 0;

  always #5 CLK = ~CLK;

  fir_result_buffer #(
    .SHIFT     (SHIFT),
    .OUT_WIDTH (OUT_WIDTH),
    .DEPTH     (DEPTH)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .RESULT            (RESULT),
    .OUTPUT_DATA_READY (OUTPUT_DATA_READY),
    .OUT_DATA          (OUT_DATA),
    .OUT_VALID         (OUT_VALID),
    .OUT_READY         (OUT_READY),
    .SAT_FLAG          (SAT_FLAG),
    .DROP_COUNT        (DROP_COUNT),
    .LEVEL             (LEVEL)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Arithmetic reference: floor division of the half-up-biased value, then clamp.
  function automatic int model_scale(input logic [31:0] res, output bit clamped);
    int x, d, y, q, hi, lo;
    x = int'(res[18:0]);
    if (res[18]) x = x - (1 << 19);
    d = 1 << SHIFT;
    y = (SHIFT > 0) ? x + d / 2 : x;
    q = (y >= 0) ? y / d : -((-y + d - 1) / d);
    hi = (1 << (OUT_WIDTH - 1)) - 1;
    lo = -(1 << (OUT_WIDTH - 1));
    clamped = (q > hi) || (q < lo);
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  always @(posedge CLK) begin
    bit c;
    int q;
    if (RESET) begin
      exp_q.delete();
      m_s1_v = 0;
      m_sat  = 0;
      m_drop = 0;
    end else begin
      if (OUT_READY && exp_q.size() > 0) void'(exp_q.pop_front());
      if (m_s1_v) begin
        if (m_s1_c) m_sat = 1;
        if (exp_q.size() < DEPTH) exp_q.push_back(m_s1_d);
        else if (m_drop < 255) m_drop++;
      end
      m_s1_v = OUTPUT_DATA_READY;
      if (OUTPUT_DATA_READY) begin
        q      = model_scale(RESULT, c);
        m_s1_d = OUT_WIDTH'(q);
        m_s1_c = c;
      end
    end
  end

  always @(negedge CLK) begin
    check("mon_valid", OUT_VALID, exp_q.size() > 0);
    check("mon_level", LEVEL, exp_q.size());
    check("mon_sat", SAT_FLAG, m_sat);
    check("mon_drop", DROP_COUNT, m_drop);
    if (exp_q.size() > 0) check("mon_data", OUT_DATA, exp_q[0]);
  end

  // Drive one cycle of inputs, return at the following negedge.
  task automatic cyc(input logic stb, input logic [31:0] res, input logic rdy);
    OUTPUT_DATA_READY = stb;
    RESULT            = res;
    OUT_READY         = rdy;
    @(negedge CLK);
  endtask

  initial begin
    logic [31:0] val;
    int          sel;

    // Reset held two cycles with strobes active
    RESET = 1'b1;
    cyc(1'b1, 32'h0000_0500, 1'b1);
    cyc(1'b1, 32'h0000_0600, 1'b1);
    RESET = 1'b0;
    check("rst_valid", OUT_VALID, 0);
    check("rst_level", LEVEL, 0);
    check("rst_sat", SAT_FLAG, 0);
    check("rst_drop", DROP_COUNT, 0);
    check("rst_data", OUT_DATA, 0);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    check("rst_strobe_ignored", LEVEL, 0);

    // Rounding with exact two-cycle latency
    cyc(1'b1, 32'h0000_0180, 1'b1);
    check("round_not_early", OUT_VALID, 0);
    cyc(1'b0, 32'h0, 1'b1);
    check("round_valid", OUT_VALID, 1);
    check("round_data", OUT_DATA, 8'h02);
    check("round_sat", SAT_FLAG, 0);

    // Negative and half-step rounding
    cyc(1'b1, 32'h0007_FF00, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    check("neg_round", OUT_DATA, 8'hFF);
    cyc(1'b1, 32'h0000_00FF, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    check("pos_half", OUT_DATA, 8'h01);

    // Saturation both ways, sticky flag
    cyc(1'b1, 32'h0003_FFFF, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    check("sat_pos", OUT_DATA, 8'h7F);
    check("sat_flag", SAT_FLAG, 1);
    cyc(1'b1, 32'h0004_0000, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);
    check("sat_neg", OUT_DATA, 8'h80);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1);
    check("sat_sticky", SAT_FLAG, 1);

    // Overflow: six strobes into a stalled FIFO
    for (int n = 1; n <= 6; n++) cyc(1'b1, 32'(n) << 8, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    check("ovf_level", LEVEL, 4);
    check("ovf_drop", DROP_COUNT, 2);
    for (int n = 1; n <= 4; n++) begin
      check("ovf_valid", OUT_VALID, 1);
      check("ovf_order", OUT_DATA, 32'(n));
      cyc(1'b0, 32'h0, 1'b1);
    end
    check("ovf_empty", OUT_VALID, 0);

    // Reset mid-operation discards queued and in-flight samples
    for (int n = 0; n < 3; n++) cyc(1'b1, 32'h0000_0300, 1'b0);
    RESET = 1'b1;
    cyc(1'b1, 32'h0000_0700, 1'b0);
    RESET = 1'b0;
    check("mid_rst_sat", SAT_FLAG, 0);
    check("mid_rst_drop", DROP_COUNT, 0);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    check("mid_rst_level", LEVEL, 0);
    check("mid_rst_valid", OUT_VALID, 0);

    // Push and pop together at full across pointer wrap
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 32'(i + 10) << 8, i >= 5);
      if (i >= 4) check("full_pp_level", LEVEL, 4);
    end
    check("full_pp_drop", DROP_COUNT, 0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b1);
    check("full_pp_drain", OUT_VALID, 0);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       val = $urandom() & 32'h0007_FFFF;
        1:       val = 32'($urandom_range(0, 65535)) - 32'd32768;
        2:       val = ($urandom_range(0, 1) != 0) ? 32'h0003_FFFF : 32'h0004_0000;
        default: val = 32'($urandom_range(0, 2047)) - 32'd1024;
      endcase
      val   = ($urandom() & 32'hFFF8_0000) | (val & 32'h0007_FFFF);
      RESET = ($urandom_range(0, 199) == 0);
      cyc($urandom_range(0, 3) != 0, val, $urandom_range(0, 2) != 0);
    end
    RESET = 1'b0;
    for (int i = 0; i < 10; i++) cyc(1'b0, 32'h0, 1'b1);
    check("final_empty", OUT_VALID, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_result_buffer.md
# fir_result_buffer

Downstream stage of the FIR top level. Consumes the 32-bit `RESULT` / `OUTPUT_DATA_READY` pair, which has no backpressure. Each result is rescaled from the 19-bit signed accumulator domain to a signed `OUT_WIDTH` sample with round-half-up and saturation. Results are queued in a small FIFO and presented on a valid/ready interface, with sticky saturation and drop status for the checker harness.

## Interface
Parameters:
- `SHIFT`, 8, right-shift applied to the accumulator (0..12)
- `OUT_WIDTH`, 8, signed output sample width (2..16)
- `DEPTH`, 4, FIFO entries (power of two, 2..16)

Ports:
- `CLK`  in  1  sole clock, rising edge
- `RESET`  in  1  synchronous, active-high; one clock, synchronous reset, active-high
- `RESULT`  in  32  FIR result; only bits [18:0] are meaningful, as signed two's complement
- `OUTPUT_DATA_READY`  in  1  result strobe; every cycle high is one sample
- `OUT_DATA`  out  OUT_WIDTH  head-of-FIFO sample, signed
- `OUT_VALID`  out  1  FIFO non-empty
- `OUT_READY`  in  1  consumer accepts `OUT_DATA` when `OUT_VALID` && `OUT_READY`
- `SAT_FLAG`  out  1  sticky; set when any sample was saturated
- `DROP_COUNT`  out  8  samples lost to a full FIFO; saturates at 255
- `LEVEL`  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- **Stage 1 (scale register):**
  - On strobe, compute x = sign-extended RESULT[18:0] to 20 bits.
  - If SHIFT>0, compute y = (x + 2^(SHIFT-1)) >>> SHIFT; if SHIFT=0, y = x.
  - Clamp y to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Register the clamped value, a valid bit and a clamped bit.
  - With no strobe, the stage-1 valid bit is 0 that cycle.
- **Stage 2 (FIFO write):**
  - A registered valid sample is pushed if the FIFO is not full, or is full with a pop in the same cycle.
  - Otherwise it is dropped, and `DROP_COUNT` increments (saturating at 255).
  - The clamped bit sets `SAT_FLAG` at the same time, whether the sample is pushed or dropped.
- **Pop:** `OUT_VALID` && `OUT_READY`. `OUT_DATA` is stable while `OUT_VALID` && !`OUT_READY`.
- **Pointers:** read and write pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH. Occupancy is a separate counter.
- **Push and pop together:**
  - Non-empty, non-full FIFO: `LEVEL` is unchanged.
  - Empty FIFO: the push happens and the pop is not possible, so `LEVEL` becomes 1. There is no bypass.
- **Status clear:** `SAT_FLAG` and `DROP_COUNT` clear only on `RESET`.

## Timing
- **Reset values:**
  - `OUT_VALID`=0, `OUT_DATA`=0, `SAT_FLAG`=0, `DROP_COUNT`=0, `LEVEL`=0.
  - Stage-1 valid=0, pointers=0.
- **Reset mid-operation:** all queued and in-flight samples are discarded. A strobe in the `RESET` cycle is ignored.
- **Latency:**
  - Strobe in cycle N: stage-1 register in N+1, FIFO entry and `LEVEL` update in N+2.
  - If the FIFO was empty, `OUT_VALID` rises in N+2.
- **Throughput:** one sample per cycle in and one out.
- **Full/empty:**
  - Full means `LEVEL`==DEPTH; empty means `LEVEL`==0.
  - `OUT_READY` while empty has no effect.
- **Drop decision:** made in the stage-2 cycle, using that cycle's pop.

## Structure
- **Package `fir_result_pkg`:**
  - `ACC_WIDTH` = 19.
  - Default `SHIFT`, `OUT_WIDTH`, `DEPTH`.
  - `DROP_MAX` = 255.
  - Function `sat_round(x, shift, width)` returning the clamped value and the clamped bit.
- **Sub-module `fir_result_fifo`:**
  - Parameterised by width and depth.
  - Ports: push, pop, din, dout, level, full, empty.
  - Holds the pointers and occupancy.
- **Top level:** scaling register, drop logic and status live in `fir_result_buffer`.

## Test plan
- **Reset:** hold `RESET` 2 cycles with strobes active. Then `OUT_VALID`=0, `LEVEL`=0, `SAT_FLAG`=0, `DROP_COUNT`=0.
- **Rounding:** `RESULT`=0x00000180, one strobe, `OUT_READY`=1. Expect `OUT_DATA`=0x02 with `OUT_VALID`=1 exactly 2 cycles after the strobe, and `SAT_FLAG`=0.
- **Negative rounding:** `RESULT`[18:0]=0x7FF00 (-256). Expect `OUT_DATA`=0xFF. Then `RESULT`=0x000000FF. Expect `OUT_DATA`=0x01.
- **Saturation:**
  - `RESULT`=0x0003FFFF gives `OUT_DATA`=0x7F and `SAT_FLAG`=1.
  - `RESULT`=0x00040000 gives `OUT_DATA`=0x80.
  - `SAT_FLAG` stays 1 afterwards.
- **Overflow:**
  - With `OUT_READY`=0, send 6 back-to-back strobes with values 1..6 scaled (RESULT=n<<8).
  - Expect `LEVEL`=4 and `DROP_COUNT`=2.
  - Then raise `OUT_READY`: outputs 1,2,3,4 in order, `OUT_VALID` falls after the 4th.
- **Simultaneous push/pop at full:**
  - Fill 4 entries, then strobe while `OUT_READY`=1 continuously.
  - `LEVEL` stays 4 and `DROP_COUNT` stays 0.
  - Read order matches write order across pointer wrap.
